// File: rtl/change_dispenser.sv
// change_dispenser: greedy 50/20/10/5/1 change payout, one ejector pulse at a time.
// Optional per-denomination stock tracking and out-of-stock fault under CHANGE_STOCK_EN.
module change_dispenser #(
    parameter int GAP_CYCLES = 4,
    parameter int STOCK_INIT = 8
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    input  logic [7:0] change_amount,
    input  logic       refill,
    output logic [4:0] coin_out,
    output logic [7:0] remaining,
    output logic       busy,
    output logic       done,
    output logic       fault
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST =
        GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    // Denomination values, slot i matches coin_out[i].
    localparam logic [39:0] DENOMS = {8'd50, 8'd20, 8'd10, 8'd5, 8'd1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_PULSE,
        S_GAP,
        S_DONE,
        S_FAULT
    } state_t;

    state_t state;
    state_t state_nx;

    logic [4:0]    stock_ok;
    logic [4:0]    avail;
    logic [4:0]    pick;
    logic [7:0]    pick_val;
    logic [4:0]    sel_q;
    logic [7:0]    sel_val_q;
    logic [GW-1:0] gap_cnt;
    logic          accept;

    assign accept = (state == S_IDLE) && start;

`ifdef CHANGE_STOCK_EN
    logic [7:0] stock [5];

    // A denomination can be paid only while its tube is not empty.
    always_comb begin
        stock_ok = '0;
        for (int i = 0; i < 5; i++) begin
            stock_ok[i] = (stock[i] != 8'd0);
        end
    end

    // Stock counters: reload on reset or idle refill, drain one per pulse.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < 5; i++) begin
                stock[i] <= 8'(STOCK_INIT);
            end
        end else if (state == S_IDLE && refill) begin
            for (int i = 0; i < 5; i++) begin
                stock[i] <= 8'(STOCK_INIT);
            end
        end else if (state == S_PULSE) begin
            for (int i = 0; i < 5; i++) begin
                if (sel_q[i] && stock[i] != 8'd0) begin
                    stock[i] <= stock[i] - 8'd1;
                end
            end
        end
    end
`else
    logic       unused_refill;
    logic [7:0] unused_stock_init;

    assign unused_refill     = refill;
    assign unused_stock_init = 8'(STOCK_INIT);
    assign stock_ok          = '1;
`endif

    // Denominations that fit in the amount still owed and are in stock.
    always_comb begin
        avail = '0;
        for (int i = 0; i < 5; i++) begin
            avail[i] = stock_ok[i] && (remaining >= DENOMS[i*8 +: 8]);
        end
    end

    // Greedy choice: largest payable denomination wins.
    always_comb begin
        pick     = '0;
        pick_val = '0;
        if (avail[4]) begin
            pick     = 5'b10000;
            pick_val = 8'd50;
        end else if (avail[3]) begin
            pick     = 5'b01000;
            pick_val = 8'd20;
        end else if (avail[2]) begin
            pick     = 5'b00100;
            pick_val = 8'd10;
        end else if (avail[1]) begin
            pick     = 5'b00010;
            pick_val = 8'd5;
        end else if (avail[0]) begin
            pick     = 5'b00001;
            pick_val = 8'd1;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_SELECT;
                end
            end
            S_SELECT: begin
                if (remaining == 8'd0) begin
                    state_nx = S_DONE;
                end else if (|avail) begin
                    state_nx = S_PULSE;
                end else begin
                    state_nx = S_FAULT;
                end
            end
            S_PULSE: begin
                state_nx = (GAP_CYCLES == 0) ? S_SELECT : S_GAP;
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    state_nx = S_SELECT;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            S_FAULT: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state    <= S_IDLE;
            coin_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            coin_out <= (state == S_SELECT && state_nx == S_PULSE) ? pick : '0;
            busy     <= (state_nx != S_IDLE);
            done     <= (state_nx == S_DONE);
        end
    end

    // Owed amount: load on accepted start, reduce after each pulse.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            remaining <= '0;
        end else if (accept) begin
            remaining <= change_amount;
        end else if (state == S_PULSE) begin
            remaining <= remaining - sel_val_q;
        end
    end

    // Latch the chosen coin so PULSE acts on the SELECT decision.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sel_q     <= '0;
            sel_val_q <= '0;
        end else if (state == S_SELECT) begin
            sel_q     <= pick;
            sel_val_q <= pick_val;
        end
    end

    // Quiet-gap counter, armed on every pulse.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            gap_cnt <= '0;
        end else if (state == S_PULSE) begin
            gap_cnt <= GAP_LAST;
        end else if (state == S_GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

    // Sticky out-of-stock flag, cleared by the next accepted start.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            fault <= 1'b0;
`ifdef CHANGE_STOCK_EN
        end else if (accept) begin
            fault <= 1'b0;
        end else if (state == S_FAULT) begin
            fault <= 1'b1;
`else
        end else begin
            fault <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: randomized and directed checks of change_dispenser
// against a payout-schedule model.
module tb_change_dispenser;

    localparam int G = 4;
    localparam int P = G + 2;
`ifdef CHANGE_STOCK_EN
    localparam int SI = 1;
`else
    localparam int SI = 8;
`endif

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       start = 1'b0;
    logic       refill = 1'b0;
    logic [7:0] change_amount = 8'd0;
    logic [4:0] coin_out;
    logic [7:0] remaining;
    logic       busy;
    logic       done;
    logic       fault;

    change_dispenser #(
        .GAP_CYCLES(G),
        .STOCK_INIT(SI)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .start(start),
        .change_amount(change_amount),
        .refill(refill),
        .coin_out(coin_out),
        .remaining(remaining),
        .busy(busy),
        .done(done),
        .fault(fault)
    );

    always #5 sys_clk = ~sys_clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Model: a payout is a coin list fixed at acceptance; outputs follow
    // from the cycle offset relative to the accepting cycle.
    bit known = 0;
    bit active = 0;
    bit fcase = 0;
    int t0 = 0;
    int amt = 0;
    int end_rel = 0;
    int coins[$];
    int stk[5];
    int den[5] = '{50, 20, 10, 5, 1};

    int pv_q[$];
    int pc_q[$];
    int exp_q[$];
    int done_cyc = -1;
    int idle_cyc = -1;
    bit prev_busy = 0;

    task automatic check(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cyc=%0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [4:0] onehot(int d);
        case (d)
            50: return 5'b10000;
            20: return 5'b01000;
            10: return 5'b00100;
            5:  return 5'b00010;
            1:  return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic int decode(logic [4:0] c);
        case (c)
            5'b10000: return 50;
            5'b01000: return 20;
            5'b00100: return 10;
            5'b00010: return 5;
            5'b00001: return 1;
            default:  return -1;
        endcase
    endfunction

    function automatic void plan(int a);
        int r;
        bit found;
        bit ok;
        coins.delete();
        fcase = 0;
        r = a;
        while (r > 0) begin
            found = 0;
            for (int i = 0; i < 5; i++) begin
                ok = (den[i] <= r);
`ifdef CHANGE_STOCK_EN
                ok = ok && (stk[i] > 0);
`endif
                if (!found && ok) begin
                    found = 1;
                    coins.push_back(den[i]);
                    r -= den[i];
`ifdef CHANGE_STOCK_EN
                    stk[i]--;
`endif
                end
            end
            if (!found) begin
                fcase = 1;
                break;
            end
        end
        end_rel = 2 + coins.size() * P;
    endfunction

    function automatic void model_edge(logic rin, logic sin, logic fin, int ain);
        bit idle_prev;
        idle_prev = !active || (cyc - 1 - t0 > end_rel);
        if (!rin) begin
            known = 1;
            active = 0;
            for (int i = 0; i < 5; i++) stk[i] = SI;
        end else if (known && idle_prev) begin
            if (fin) begin
                for (int i = 0; i < 5; i++) stk[i] = SI;
            end
            if (sin) begin
                active = 1;
                t0 = cyc - 1;
                amt = ain;
                plan(ain);
            end
        end
    endfunction

    // Compare process: advance the model at each edge, check just after it.
    always @(posedge sys_clk) begin : cmp
        logic rin, sin, fin;
        logic [7:0] ain;
        int rel, r, e_rem;
        logic [4:0] e_coin;
        logic e_busy, e_done, e_fault;
        rin = sys_rst_n;
        sin = start;
        fin = refill;
        ain = change_amount;
        cyc++;
        model_edge(rin, sin, fin, int'(ain));
        #1;
        if (known) begin
            e_coin = '0;
            e_busy = 0;
            e_done = 0;
            e_fault = 0;
            e_rem = 0;
            if (active) begin
                rel = cyc - t0;
                e_busy = (rel >= 1) && (rel <= end_rel);
                e_done = !fcase && (rel == end_rel);
                e_fault = fcase && (rel > end_rel);
                e_rem = amt;
                for (int k = 0; k < coins.size(); k++) begin
                    if (2 + k * P < rel) e_rem -= coins[k];
                end
                r = rel - 2;
                if (r >= 0 && r % P == 0 && r / P < coins.size())
                    e_coin = onehot(coins[r / P]);
            end
            check("coin_out", int'(coin_out), int'(e_coin));
            check("remaining", int'(remaining), e_rem);
            check("busy", int'(busy), int'(e_busy));
            check("done", int'(done), int'(e_done));
            check("fault", int'(fault), int'(e_fault));
            if (coin_out != '0) begin
                pv_q.push_back(decode(coin_out));
                pc_q.push_back(cyc);
            end
            if (done) done_cyc = cyc;
            if (prev_busy && !busy) idle_cyc = cyc;
            prev_busy = busy;
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge sys_clk);
        #2;
    endtask

    task automatic begin_txn(int a, bit rf, output int t);
        change_amount = 8'(a);
        refill = rf;
        start = 1'b1;
        t = cyc;
        pv_q.delete();
        pc_q.delete();
        done_cyc = -1;
        idle_cyc = -1;
        step(1);
        start = 1'b0;
        refill = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 300) begin
            step(1);
            k++;
        end
        if (k >= 300) check("idle_timeout", int'(busy), 0);
    endtask

    task automatic check_pulses(string nm, int t);
        check({nm, "_npulse"}, pv_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < pv_q.size(); i++) begin
            check({nm, "_coin"}, pv_q[i], exp_q[i]);
            check({nm, "_coin_t"}, pc_q[i] - t, 2 + P * i);
        end
    endtask

    initial begin : stim
        int t;
        step(2);
        check("rst_busy", int'(busy), 0);
        check("rst_coin", int'(coin_out), 0);
        check("rst_rem", int'(remaining), 0);
        check("rst_fault", int'(fault), 0);
        sys_rst_n = 1'b1;
        step(2);

        // 37 with an ignored start of 99 four cycles in.
        begin_txn(37, 1, t);
        step(3);
        change_amount = 8'd99;
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_idle();
        step(2);
`ifdef CHANGE_STOCK_EN
        exp_q = '{20, 10, 5, 1};
        check_pulses("g37", t);
        check("g37_fault", int'(fault), 1);
        check("g37_rem", int'(remaining), 1);
        check("g37_idle", idle_cyc - t, 27);
`else
        exp_q = '{20, 10, 5, 1, 1};
        check_pulses("g37", t);
        check("g37_done", done_cyc - t, 32);
        check("g37_idle", idle_cyc - t, 33);
        check("g37_rem", int'(remaining), 0);
`endif

        // Zero amount.
        begin_txn(0, 0, t);
        wait_idle();
        step(1);
        exp_q = {};
        check_pulses("z0", t);
        check("z0_done", done_cyc - t, 2);
        check("z0_idle", idle_cyc - t, 3);

        // Maximum amount.
        begin_txn(255, 1, t);
        wait_idle();
        step(2);
`ifdef CHANGE_STOCK_EN
        exp_q = '{50, 20, 10, 5, 1};
        check_pulses("m255", t);
        check("m255_rem", int'(remaining), 169);
        check("m255_fault", int'(fault), 1);
`else
        exp_q = '{50, 50, 50, 50, 50, 5};
        check_pulses("m255", t);
        check("m255_done", done_cyc - t, 38);
        check("m255_rem", int'(remaining), 0);
`endif

        // Amount 3, then refill and a single-unit payout.
        begin_txn(3, 1, t);
        wait_idle();
        step(2);
`ifdef CHANGE_STOCK_EN
        exp_q = '{1};
        check_pulses("a3", t);
        check("a3_fault", int'(fault), 1);
        check("a3_rem", int'(remaining), 2);
`else
        exp_q = '{1, 1, 1};
        check_pulses("a3", t);
        check("a3_rem", int'(remaining), 0);
`endif
        refill = 1'b1;
        step(1);
        refill = 1'b0;
        step(1);
        begin_txn(1, 0, t);
        wait_idle();
        step(1);
        exp_q = '{1};
        check_pulses("a1", t);
        check("a1_done", done_cyc - t, 2 + P);
        check("a1_fault", int'(fault), 0);

        // Amount 40 skips empty tubes when stock is tracked.
        begin_txn(40, 1, t);
        wait_idle();
        step(2);
`ifdef CHANGE_STOCK_EN
        exp_q = '{20, 10, 5, 1};
        check_pulses("s40", t);
        check("s40_rem", int'(remaining), 4);
        check("s40_fault", int'(fault), 1);
`else
        exp_q = '{20, 20};
        check_pulses("s40", t);
        check("s40_done", done_cyc - t, 2 + 2 * P);
`endif

        // Reset right after the second coin of 37.
        begin_txn(37, 1, t);
        while (cyc < t + 8) step(1);
        sys_rst_n = 1'b0;
        step(1);
        sys_rst_n = 1'b1;
        check("rm_busy", int'(busy), 0);
        check("rm_coin", int'(coin_out), 0);
        check("rm_rem", int'(remaining), 0);
        check("rm_done", int'(done), 0);
        check("rm_fault", int'(fault), 0);
        exp_q = '{20, 10};
        check_pulses("rm", t);
        step(1);
        begin_txn(5, 0, t);
        wait_idle();
        step(1);
        exp_q = '{5};
        check_pulses("r5", t);

        // Randomized traffic with stray starts, refills and resets.
        for (int it = 0; it < 40; it++) begin
            begin_txn(int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)), t);
            for (int k = 0; k < 60 && busy; k++) begin
                start = ($urandom_range(0, 7) == 0);
                change_amount = 8'($urandom);
                refill = ($urandom_range(0, 7) == 0);
                sys_rst_n = ($urandom_range(0, 40) != 0);
                step(1);
            end
            start = 1'b0;
            refill = 1'b0;
            sys_rst_n = 1'b1;
            step(1);
            wait_idle();
            step(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
